// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding and
// elaboration-time sizing helpers.
package addsub_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk build still needs a 1-bit index register.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_seq_fa_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from 1-bit full adders.
// Also exposes the carry into the chunk MSB for signed-overflow detection.
module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic c;

  always_comb begin
    c    = cin;
    sum  = '0;
    cmsb = cin;
    for (int unsigned k = 0; k < CHUNK; k++) begin
      if (k == 32'(CHUNK - 1)) cmsb = c;
      sum[k] = a[k] ^ b[k] ^ c;
      c      = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
    cout = c;
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock
// with a start/done handshake; results appear only on the done edge.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r, work, work_nxt;
  logic             c_r;
  logic [CW-1:0]    idx;
  logic             ld, step, fin, last;

  int unsigned      base;
  logic [CHUNK-1:0] a_slice, b_slice, c_sum;
  logic             c_out, c_msb;

  assign last = (idx == CW'(NCHUNK - 1));
  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ld        = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slices are selected by shifting so the index arithmetic stays 32-bit;
  // the working register is cleared on accept, so OR-ing in each chunk suffices.
  always_comb begin
    base     = CHUNK * 32'(idx);
    a_slice  = CHUNK'(a_r >> base);
    b_slice  = CHUNK'(b_r >> base);
    work_nxt = work | (WIDTH'(c_sum) << base);
  end

  fa_chunk #(.CHUNK(CHUNK)) u_fa_chunk (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (c_r),
    .sum  (c_sum),
    .cout (c_out),
    .cmsb (c_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= 1'b0;
      idx  <= '0;
      work <= '0;
      done <= 1'b0;
      Sum  <= '0;
      Cout <= 1'b0;
      Ovf  <= 1'b0;
    end else begin
      done <= fin;
      if (ld) begin
        a_r  <= A;
        b_r  <= B ^ {WIDTH{Sub}};
        c_r  <= Cin ^ Sub;
        idx  <= '0;
        work <= '0;
      end else if (step) begin
        work <= work_nxt;
        c_r  <= c_out;
        idx  <= idx + 1'b1;
      end
      if (fin) begin
        Sum  <= work_nxt;
        Cout <= c_out;
        Ovf  <= c_msb ^ c_out;
      end
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: CHUNK=4 directed checks plus random
// traffic on CHUNK=16 and CHUNK=1 builds, all at WIDTH=16.
module tb_addsub_seq;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [15:0] A, B;
  logic        Cin, Sub;
  logic [2:0]  busy_v, done_v, cout_v, ovf_v;
  logic [15:0] sum_v [3];

  res_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   lat_exp [3] = '{4, 1, 16};

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .start(start[0]), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .busy(busy_v[0]), .done(done_v[0]), .Sum(sum_v[0]), .Cout(cout_v[0]), .Ovf(ovf_v[0]));

  addsub_seq #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .start(start[1]), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .busy(busy_v[1]), .done(done_v[1]), .Sum(sum_v[1]), .Cout(cout_v[1]), .Ovf(ovf_v[1]));

  addsub_seq #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start[2]), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .busy(busy_v[2]), .done(done_v[2]), .Sum(sum_v[2]), .Cout(cout_v[2]), .Ovf(ovf_v[2]));

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    logic [15:0] be;
    logic [16:0] full;
    be     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + {16'h0, cin ^ sub};
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (a[15] == be[15]) && (full[15] != a[15]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    A = a; B = b; Cin = cin; Sub = sub;
    start[sel] = 1'b1;
    sb.push_back(model(a, b, cin, sub));
  endtask

  // Leaves the bench at the negedge following the accepting edge.
  task automatic issue(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    @(negedge clk);
    drive(sel, a, b, cin, sub);
    @(negedge clk);
    start[sel] = 1'b0;
  endtask

  // lat0 = edges already elapsed since the accepting edge.
  task automatic wait_done(input int sel, input int lat0, input string tag);
    int   lat;
    res_t r;
    lat = lat0;
    while (!done_v[sel] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, lat_exp[sel]);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_scoreboard: observed done with empty queue", tag);
    end else begin
      r = sb.pop_front();
      chk({tag, "_sum"},  sum_v[sel],  r.sum);
      chk({tag, "_cout"}, cout_v[sel], r.cout);
      chk({tag, "_ovf"},  ovf_v[sel],  r.ovf);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, done_v[sel], 1'b0);
  endtask

  task automatic count_dones(input int cycles, input string tag);
    int n;
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done_v[0]) n++;
    end
    chk(tag, n, 0);
  endtask

  initial begin
    rst = 1'b1; start = '0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_busy", busy_v[s], 1'b0);
      chk("rst_done", done_v[s], 1'b0);
      chk("rst_sum",  sum_v[s],  16'h0000);
      chk("rst_cout", cout_v[s], 1'b0);
      chk("rst_ovf",  ovf_v[s],  1'b0);
    end

    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("run_busy", busy_v[0], 1'b1);
    wait_done(0, 0, "wrap");
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(0, 0, "ovf");
    issue(0, 16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(0, 0, "sub");
    issue(0, 16'h8000, 16'h0001, 1'b1, 1'b1);
    wait_done(0, 0, "sub_borrow");

    // Second start while busy must not disturb the running operation.
    issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; start[0] = 1'b1;
    chk("ign_busy", busy_v[0], 1'b1);
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 2, "ignored");
    count_dones(8, "ignored_extra_done");

    issue(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy", busy_v[0], 1'b0);
    chk("abort_sum",  sum_v[0],  16'h0000);
    chk("abort_cout", cout_v[0], 1'b0);
    chk("abort_ovf",  ovf_v[0],  1'b0);
    count_dones(8, "abort_done");

    // start held through the done cycle: next op is accepted right after it.
    @(negedge clk);
    drive(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
    wait_done(0, 0, "held1");
    start[0] = 1'b0;
    wait_done(0, 0, "held2");

    for (int s = 1; s < 3; s++) begin
      for (int n = 0; n < 1000; n++) begin
        issue(s, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        wait_done(s, 0, (s == 1) ? "rnd_c16" : "rnd_c1");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
